// File: rtl/enclosure_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enclosure_led_ctrl
// Purpose  : Policy arbiter for the two enclosure LEDs (lamp test, override,
//            faults, locate, power status) feeding the LED wave driver.
// Revision : 1.0 - initial release
// ============================================================================
module enclosure_led_ctrl #(
    parameter int         CLK_FRQ       = 25_000_000,
    parameter int         LAMP_TEST_CYC = 50_000_000,
    parameter int         LOCATE_SEC    = 15,
    parameter logic [3:0] MODE_OFF      = 4'h0,
    parameter logic [3:0] MODE_ON       = 4'h1,
    parameter logic [3:0] MODE_BLINK    = 4'h2
) (
    input  logic       SYSCLK,
    input  logic       RESET_N,
    input  logic       PWR_GOOD,
    input  logic [3:0] FAULT_IN,
    input  logic       FAULT_CLR,
    input  logic       LOCATE_REQ,
    input  logic       LOCATE_CANCEL,
    input  logic       OVR_WR,
    input  logic [7:0] OVR_DATA,
    input  logic       OVR_REL,
    output logic [7:0] LED_REG,
    output logic       STATE,
    output logic [3:0] FAULT_LATCH,
    output logic       LOCATE_ACT
);

    localparam logic [31:0] c_LAMP_LAST = 32'(LAMP_TEST_CYC - 1);
    localparam logic [31:0] c_LOC_LOAD  = 32'(LOCATE_SEC * CLK_FRQ - 1);

    typedef enum logic [0:0] {
        ST_LAMP   = 1'b0,
        ST_NORMAL = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_lamp_cnt;
    logic        r_pg_s1, r_pg_s2, r_pwr_ok;
    logic [3:0]  r_flt_s1, r_flt_s2;
    logic [31:0] r_loc_cnt;
    logic        r_ovr_act;
    logic [7:0]  r_ovr_val;
    logic [3:0]  w_led0, w_led1;
    logic [7:0]  w_policy;

    function automatic logic [3:0] f_sanitize(input logic [3:0] n);
        return (n == MODE_OFF || n == MODE_ON || n == MODE_BLINK) ? n : MODE_OFF;
    endfunction

    // Power-good gets one stage past its synchronizer so it lines up with the
    // fault path (sync, latch, LED).
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pg_s1  <= 1'b0;
            r_pg_s2  <= 1'b0;
            r_pwr_ok <= 1'b0;
            r_flt_s1 <= 4'h0;
            r_flt_s2 <= 4'h0;
        end else begin
            r_pg_s1  <= PWR_GOOD;
            r_pg_s2  <= r_pg_s1;
            r_pwr_ok <= r_pg_s2;
            r_flt_s1 <= FAULT_IN;
            r_flt_s2 <= r_flt_s1;
        end
    end

    // Clear only drops bits whose source is gone; a live source always re-sets.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FAULT_LATCH <= 4'h0;
        end else if (FAULT_CLR) begin
            FAULT_LATCH <= (FAULT_LATCH & r_flt_s2) | r_flt_s2;
        end else begin
            FAULT_LATCH <= FAULT_LATCH | r_flt_s2;
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LOCATE_ACT <= 1'b0;
            r_loc_cnt  <= 32'd0;
        end else if (LOCATE_CANCEL) begin
            LOCATE_ACT <= 1'b0;
        end else if (LOCATE_REQ) begin
            LOCATE_ACT <= 1'b1;
            r_loc_cnt  <= c_LOC_LOAD;
        end else if (LOCATE_ACT) begin
            if (r_loc_cnt == 32'd0) begin
                LOCATE_ACT <= 1'b0;
            end else begin
                r_loc_cnt <= r_loc_cnt - 32'd1;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ovr_act <= 1'b0;
            r_ovr_val <= 8'h00;
        end else if (OVR_WR) begin
            r_ovr_act <= 1'b1;
            r_ovr_val <= {f_sanitize(OVR_DATA[7:4]), f_sanitize(OVR_DATA[3:0])};
        end else if (OVR_REL) begin
            r_ovr_act <= 1'b0;
        end
    end

    always_comb begin
        w_led0   = r_pwr_ok ? MODE_ON : MODE_OFF;
        w_led1   = (FAULT_LATCH != 4'h0) ? MODE_ON :
                   (LOCATE_ACT ? MODE_BLINK : MODE_OFF);
        w_policy = r_ovr_act ? r_ovr_val : {w_led1, w_led0};
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_LAMP;
            r_lamp_cnt <= 32'd0;
            LED_REG    <= 8'h00;
        end else if (r_state == ST_LAMP) begin
            LED_REG    <= {MODE_ON, MODE_ON};
            r_lamp_cnt <= r_lamp_cnt + 32'd1;
            if (r_lamp_cnt == c_LAMP_LAST) begin
                r_state <= ST_NORMAL;
            end
        end else begin
            LED_REG <= w_policy;
        end
    end

    assign STATE = (r_state == ST_NORMAL);

endmodule
`default_nettype wire

// File: tb/tb_enclosure_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_enclosure_led_ctrl
// Purpose  : Scenario bench for enclosure_led_ctrl against a cycle-level
//            behavioural model of the LED policy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enclosure_led_ctrl;

    localparam int LAMP    = 20;
    localparam int LOC_CYC = 200;

    logic       SYSCLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       PWR_GOOD = 1'b1;
    logic [3:0] FAULT_IN = 4'h0;
    logic       FAULT_CLR = 1'b0;
    logic       LOCATE_REQ = 1'b0;
    logic       LOCATE_CANCEL = 1'b0;
    logic       OVR_WR = 1'b0;
    logic [7:0] OVR_DATA = 8'h00;
    logic       OVR_REL = 1'b0;
    logic [7:0] LED_REG;
    logic       STATE;
    logic [3:0] FAULT_LATCH;
    logic       LOCATE_ACT;

    int n_chk = 0;
    int n_pass = 0;

    enclosure_led_ctrl #(
        .CLK_FRQ(100), .LAMP_TEST_CYC(LAMP), .LOCATE_SEC(2)
    ) dut (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .PWR_GOOD(PWR_GOOD),
        .FAULT_IN(FAULT_IN), .FAULT_CLR(FAULT_CLR), .LOCATE_REQ(LOCATE_REQ),
        .LOCATE_CANCEL(LOCATE_CANCEL), .OVR_WR(OVR_WR), .OVR_DATA(OVR_DATA),
        .OVR_REL(OVR_REL), .LED_REG(LED_REG), .STATE(STATE),
        .FAULT_LATCH(FAULT_LATCH), .LOCATE_ACT(LOCATE_ACT)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Model: edges since reset, remaining locate cycles, input history.
    int         m_edges, m_left;
    logic [3:0] m_flt, fh1, fh2;
    logic       ph1, ph2, ph3, m_ovr;
    logic [7:0] m_oval, m_led;
    logic [13:0] exp_all;

    function automatic logic [3:0] legal(input logic [3:0] n);
        return (n <= 4'h2) ? n : 4'h0;
    endfunction

    always @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_edges = 0; m_left = 0; m_flt = 0; fh1 = 0; fh2 = 0;
            ph1 = 0; ph2 = 0; ph3 = 0; m_ovr = 0; m_oval = 0; m_led = 0;
        end else begin
            if (m_edges < LAMP)  m_led = 8'h11;
            else if (m_ovr)      m_led = m_oval;
            else m_led = {(m_flt != 0) ? 4'h1 : ((m_left != 0) ? 4'h2 : 4'h0),
                          ph3 ? 4'h1 : 4'h0};
            m_flt = (FAULT_CLR ? (m_flt & fh2) : m_flt) | fh2;
            fh2 = fh1; fh1 = FAULT_IN;
            ph3 = ph2; ph2 = ph1; ph1 = PWR_GOOD;
            if (LOCATE_CANCEL)   m_left = 0;
            else if (LOCATE_REQ) m_left = LOC_CYC;
            else if (m_left > 0) m_left = m_left - 1;
            if (OVR_WR) begin
                m_ovr = 1'b1;
                m_oval = {legal(OVR_DATA[7:4]), legal(OVR_DATA[3:0])};
            end else if (OVR_REL) begin
                m_ovr = 1'b0;
            end
            if (m_edges < 1000000) m_edges = m_edges + 1;
        end
    end

    always_comb exp_all = {m_led, (m_edges >= LAMP), m_flt, (m_left != 0)};

    task automatic step();
        @(negedge SYSCLK);
        LOCATE_REQ = 0; LOCATE_CANCEL = 0; FAULT_CLR = 0; OVR_WR = 0; OVR_REL = 0;
    endtask

    task automatic test_reset();
        int n11 = 0;
        repeat (2) @(negedge SYSCLK);
        n_chk++;
        if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== 14'h0)
            $display("FAIL reset_values got=%h exp=%h", {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, 14'h0);
        else n_pass++;
        RESET_N = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            n_chk++;
            if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== exp_all)
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, exp_all);
            else n_pass++;
            if (LED_REG == 8'h11) n11++;
        end
        n_chk++;
        if (n11 != LAMP) $display("FAIL lamp_length got=%0d exp=%0d", n11, LAMP);
        else n_pass++;
        n_chk++;
        if ({LED_REG, STATE} !== {8'h01, 1'b1})
            $display("FAIL normal_entry got=%h/%b exp=01/1", LED_REG, STATE);
        else n_pass++;
    endtask

    task automatic test_locate(input bit rereq);
        int  hi = 0;
        int  want = rereq ? 350 : 200;
        LOCATE_REQ = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            n_chk++;
            if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== exp_all)
                $display("FAIL locate_model cyc=%0d got=%h exp=%h", i, {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, exp_all);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if (LED_REG !== 8'h21) $display("FAIL locate_led got=%h exp=21", LED_REG);
                else n_pass++;
            end
            if (LOCATE_ACT) hi++;
            else if (hi > 0) break;
            if (rereq && hi == 150) LOCATE_REQ = 1;
        end
        n_chk++;
        if (hi != want) $display("FAIL locate_duration got=%0d exp=%0d", hi, want);
        else n_pass++;
        step();
        n_chk++;
        if (LED_REG !== 8'h01) $display("FAIL locate_end_led got=%h exp=01", LED_REG);
        else n_pass++;
    endtask

    task automatic test_fault();
        LOCATE_REQ = 1;
        repeat (3) step();
        FAULT_IN = 4'b0100;
        repeat (5) step();
        n_chk++;
        if ({LED_REG, FAULT_LATCH} !== {8'h11, 4'b0100})
            $display("FAIL fault_set got=%h/%b exp=11/0100", LED_REG, FAULT_LATCH);
        else n_pass++;
        FAULT_CLR = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== exp_all)
                $display("FAIL fault_model cyc=%0d got=%h exp=%h", i, {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, exp_all);
            else n_pass++;
        end
        n_chk++;
        if ({LED_REG, FAULT_LATCH} !== {8'h11, 4'b0100})
            $display("FAIL fault_clr_live got=%h/%b exp=11/0100", LED_REG, FAULT_LATCH);
        else n_pass++;
        FAULT_IN = 4'b0000;
        repeat (4) step();
        FAULT_CLR = 1;
        repeat (3) step();
        n_chk++;
        if ({LED_REG, FAULT_LATCH} !== {8'h21, 4'b0000})
            $display("FAIL fault_clr_dead got=%h/%b exp=21/0000", LED_REG, FAULT_LATCH);
        else n_pass++;
        LOCATE_CANCEL = 1;
        repeat (3) step();
    endtask

    task automatic test_override();
        FAULT_IN = 4'b0001;
        repeat (5) step();
        OVR_WR = 1; OVR_DATA = 8'h72;
        repeat (2) step();
        n_chk++;
        if (LED_REG !== 8'h02) $display("FAIL ovr_value got=%h exp=02", LED_REG);
        else n_pass++;
        OVR_REL = 1;
        repeat (2) step();
        n_chk++;
        if (LED_REG !== 8'h11) $display("FAIL ovr_release got=%h exp=11", LED_REG);
        else n_pass++;
        FAULT_IN = 4'b0000;
        repeat (3) step();
        FAULT_CLR = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== exp_all)
                $display("FAIL ovr_model cyc=%0d got=%h exp=%h", i, {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, exp_all);
            else n_pass++;
        end
    endtask

    task automatic test_collisions();
        LOCATE_REQ = 1; LOCATE_CANCEL = 1;
        step();
        n_chk++;
        if (LOCATE_ACT !== 1'b0) $display("FAIL coll_locate got=%b exp=0", LOCATE_ACT);
        else n_pass++;
        OVR_WR = 1; OVR_REL = 1; OVR_DATA = 8'h12;
        repeat (2) step();
        n_chk++;
        if (LED_REG !== 8'h12) $display("FAIL coll_ovr got=%h exp=12", LED_REG);
        else n_pass++;
        OVR_REL = 1;
        FAULT_IN = 4'b1000;
        repeat (2) step();
        FAULT_CLR = 1;
        step();
        n_chk++;
        if (FAULT_LATCH !== 4'b1000) $display("FAIL coll_fault got=%b exp=1000", FAULT_LATCH);
        else n_pass++;
        FAULT_IN = 4'b0000;
        repeat (3) step();
        FAULT_CLR = 1;
        repeat (3) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) PWR_GOOD = ~PWR_GOOD;
            if ($urandom_range(0, 29) == 0) FAULT_IN = FAULT_IN ^ (4'b0001 << $urandom_range(0, 3));
            FAULT_CLR     = ($urandom_range(0, 15) == 0);
            LOCATE_REQ    = ($urandom_range(0, 249) == 0);
            LOCATE_CANCEL = ($urandom_range(0, 399) == 0);
            OVR_WR        = ($urandom_range(0, 99) == 0);
            OVR_REL       = ($urandom_range(0, 49) == 0);
            OVR_DATA      = 8'($urandom);
            step();
            n_chk++;
            if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== exp_all)
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, exp_all);
            else n_pass++;
        end
        PWR_GOOD = 1; FAULT_IN = 0;
        repeat (5) step();
    endtask

    task automatic test_reset_mid();
        int n11 = 0;
        LOCATE_REQ = 1; OVR_WR = 1; OVR_DATA = 8'h21;
        repeat (10) step();
        #2 RESET_N = 1'b0;
        #1;
        n_chk++;
        if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== 14'h0)
            $display("FAIL midreset_clear got=%h exp=%h", {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, 14'h0);
        else n_pass++;
        @(negedge SYSCLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_chk++;
            if ({LED_REG, STATE, FAULT_LATCH, LOCATE_ACT} !== exp_all)
                $display("FAIL midreset_model cyc=%0d got=%h exp=%h", i, {LED_REG, STATE, FAULT_LATCH, LOCATE_ACT}, exp_all);
            else n_pass++;
            if (LED_REG == 8'h11) n11++;
        end
        n_chk++;
        if (n11 != LAMP || LED_REG !== 8'h01)
            $display("FAIL midreset_relamp lamp=%0d led=%h exp=%0d/01", n11, LED_REG, LAMP);
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_locate(1'b0);
        test_locate(1'b1);
        test_fault();
        test_override();
        test_collisions();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
